// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_pkg
// Brief    : Shared op encodings, FSM states and defaults for the SRAM arbiter.
// Revision : 1.0
// ============================================================================
package sram_port_arbiter_pkg;

    localparam int KICP_SRAM_AWIDTH = 8;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reserved encoding 2'b10 deliberately falls through as "no request".
    function automatic logic is_request(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_rr_arbiter
// Brief    : Winner select (round-robin or fixed priority) plus RR pointer.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter_rr_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_update,
    output logic [2:0]        o_winner,
    output logic              o_valid
);

    localparam logic [2:0] c_ptr_init = 3'(NUM_CH - 1);
    localparam logic [3:0] c_num_ch   = 4'(NUM_CH);

    logic [2:0] r_ptr;
    logic [3:0] w_start;
    logic [3:0] w_pos;
    logic [7:0] w_req8;

    // Fixed priority is the same search started from channel 0 every time.
    assign w_start = (PRIO_MODE != 0) ? 4'd0 : ({1'b0, r_ptr} + 4'd1);
    assign w_req8  = 8'(i_req);

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_pos    = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            w_pos = w_start + 4'(j);
            if (w_pos >= c_num_ch) begin
                w_pos = w_pos - c_num_ch;
            end
            if (w_req8[w_pos[2:0]]) begin
                o_winner = w_pos[2:0];
                o_valid  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= c_ptr_init;
        end else if (i_update && o_valid) begin
            r_ptr <= o_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : N-channel arbiter serialising DMA transactions onto one SRAM port.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int AWIDTH     = KICP_SRAM_AWIDTH,
    parameter int DWIDTH     = 32,
    parameter int RD_LATENCY = 1,
    parameter int PRIO_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*NUM_CH-1:0]        req_op,
    input  logic [NUM_CH*AWIDTH-1:0]   req_addr,
    input  logic [NUM_CH*DWIDTH-1:0]   req_data,
    input  logic [NUM_CH*DWIDTH/8-1:0] req_sel,
    output logic [NUM_CH-1:0]          done,
    output logic [DWIDTH-1:0]          rd_data,
    output logic [2:0]                 grant_id,
    output logic                       busy,
    output logic                       sram_en,
    output logic [DWIDTH/8-1:0]        sram_we,
    output logic [AWIDTH-1:0]          sram_addr,
    output logic [DWIDTH-1:0]          sram_di,
    input  logic [DWIDTH-1:0]          sram_do
);

    localparam int         c_sel_w     = DWIDTH / 8;
    localparam logic [1:0] c_wait_last = 2'(RD_LATENCY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   w_req;
    logic [2:0]          w_winner;
    logic                w_valid;
    logic                w_grant;
    logic                w_capture;
    logic [1:0]          w_mux_op;
    logic [AWIDTH-1:0]   w_mux_addr;
    logic [DWIDTH-1:0]   w_mux_data;
    logic [c_sel_w-1:0]  w_mux_sel;

    logic [1:0]          r_op;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_data;
    logic [c_sel_w-1:0]  r_sel;
    logic [2:0]          r_grant_id;
    logic [DWIDTH-1:0]   r_rd_data;
    logic [1:0]          r_wait_cnt;

    always_comb begin
        w_req      = '0;
        w_mux_op   = OP_NONE;
        w_mux_addr = '0;
        w_mux_data = '0;
        w_mux_sel  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_req[i] = is_request(req_op[2*i +: 2]);
            if (w_winner == 3'(i)) begin
                w_mux_op   = req_op[2*i +: 2];
                w_mux_addr = req_addr[i*AWIDTH +: AWIDTH];
                w_mux_data = req_data[i*DWIDTH +: DWIDTH];
                w_mux_sel  = req_sel[i*c_sel_w +: c_sel_w];
            end
        end
    end

    sram_port_arbiter_rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (reset),
        .i_req    (w_req),
        .i_update (w_grant),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = (r_op == OP_WR) ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        busy      = (r_state != ST_IDLE);
        sram_en   = (r_state == ST_ISSUE);
        sram_we   = (sram_en && (r_op == OP_WR)) ? r_sel : '0;
        sram_addr = r_addr;
        sram_di   = r_data;
        rd_data   = r_rd_data;
        grant_id  = r_grant_id;
        for (int i = 0; i < NUM_CH; i++) begin
            done[i] = (r_state == ST_DONE) && (r_grant_id == 3'(i));
        end
    end

    // Request fields are latched once at grant; later changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= OP_NONE;
            r_addr     <= '0;
            r_data     <= '0;
            r_sel      <= '0;
            r_grant_id <= '0;
            r_rd_data  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_op       <= w_mux_op;
                r_addr     <= w_mux_addr;
                r_data     <= w_mux_data;
                r_sel      <= w_mux_sel;
                r_grant_id <= w_winner;
            end
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
            if (w_capture) begin
                r_rd_data <= sram_do;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Self-checking bench: default, fixed-priority and 3-cycle-latency
//            instances, each with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
module tb_sram_port_arbiter;

    localparam int NCH = 4;
    localparam int LAT0 = 1;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic [2*NCH-1:0]  op_v   [3];
    logic [NCH*8-1:0]  addr_v [3];
    logic [NCH*32-1:0] data_v [3];
    logic [NCH*4-1:0]  sel_v  [3];
    logic [NCH-1:0]    done_v [3];
    logic [31:0]       rd_v   [3];
    logic [2:0]        gid_v  [3];
    logic              busy_v [3];
    logic              en_v   [3];
    logic [3:0]        we_v   [3];
    logic [7:0]        sa_v   [3];
    logic [31:0]       di_v   [3];
    logic [31:0]       do_v   [3];

    // Instance 0: defaults. 1: fixed priority. 2: read latency 3.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 2) ? 3 : 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        sram_port_arbiter #(
            .NUM_CH     (NCH),
            .AWIDTH     (8),
            .DWIDTH     (32),
            .RD_LATENCY (LAT),
            .PRIO_MODE  ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .req_op    (op_v[k]),
            .req_addr  (addr_v[k]),
            .req_data  (data_v[k]),
            .req_sel   (sel_v[k]),
            .done      (done_v[k]),
            .rd_data   (rd_v[k]),
            .grant_id  (gid_v[k]),
            .busy      (busy_v[k]),
            .sram_en   (en_v[k]),
            .sram_we   (we_v[k]),
            .sram_addr (sa_v[k]),
            .sram_di   (di_v[k]),
            .sram_do   (do_v[k])
        );

        always @(posedge clk) begin
            if (en_v[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (we_v[k][b]) mem[sa_v[k]][8*b +: 8] <= di_v[k][8*b +: 8];
                end
                if (we_v[k] == 4'b0000) pipe[0] <= mem[sa_v[k]];
            end
            for (int p = 1; p < LAT; p++) pipe[p] <= pipe[p-1];
        end
        assign do_v[k] = pipe[LAT-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of instance 0: one grant, then a fixed timeline.
    int          m_idle, m_k, m_d, m_ptr, m_w, m_c;
    logic [2:0]  m_gid;
    logic [31:0] m_rd, m_data;
    logic [1:0]  m_op;
    logic [7:0]  m_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_mem [256];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_idle = 1; m_k = 0; m_d = 0; m_gid = '0; m_rd = '0; m_ptr = NCH - 1;
                m_op = 2'b00; m_addr = '0; m_data = '0; m_sel = '0;
            end else if (m_idle != 0) begin
                m_w = -1;
                for (int j = 1; j <= NCH; j++) begin
                    m_c = (m_ptr + j) % NCH;
                    if (m_w < 0 && (op_v[0][2*m_c +: 2] == RD || op_v[0][2*m_c +: 2] == WR)) m_w = m_c;
                end
                if (m_w >= 0) begin
                    m_op   = op_v[0][2*m_w +: 2];
                    m_addr = addr_v[0][8*m_w +: 8];
                    m_data = data_v[0][32*m_w +: 32];
                    m_sel  = sel_v[0][4*m_w +: 4];
                    m_ptr  = m_w;
                    m_gid  = 3'(m_w);
                    m_d    = (m_op == WR) ? 2 : 2 + LAT0;
                    m_k    = 1;
                    m_idle = 0;
                end
            end else begin
                if (m_k == 1 && m_op == WR) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_sel[b]) m_mem[m_addr][8*b +: 8] = m_data[8*b +: 8];
                    end
                end
                if (m_k == m_d) begin
                    m_idle = 1;
                end else begin
                    m_k++;
                    if (m_k == m_d && m_op == RD) m_rd = m_mem[m_addr];
                end
            end
        end
    end

    initial begin
        logic [3:0] e_done, e_we;
        logic       e_busy, e_en;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (rst) begin
                    e_done = '0; e_we = '0; e_busy = 1'b0; e_en = 1'b0;
                end else begin
                    e_busy = (m_idle == 0);
                    e_en   = e_busy && (m_k == 1);
                    e_we   = (e_en && m_op == WR) ? m_sel : 4'b0000;
                    e_done = (e_busy && m_k == m_d) ? (4'b0001 << m_gid) : 4'b0000;
                end
                check("m_done", 32'(done_v[0]), 32'(e_done));
                check("m_busy", 32'(busy_v[0]), 32'(e_busy));
                check("m_sram_en", 32'(en_v[0]), 32'(e_en));
                check("m_sram_we", 32'(we_v[0]), 32'(e_we));
                check("m_grant_id", 32'(gid_v[0]), 32'(m_gid));
                check("m_rd_data", rd_v[0], m_rd);
                if (e_en) begin
                    check("m_sram_addr", 32'(sa_v[0]), 32'(m_addr));
                    check("m_sram_di", di_v[0], m_data);
                end
            end
        end
    end

    // Drives one request from cycle 0 and returns cycles until done (-1 = timeout).
    task automatic run_txn(input int k, input int ch, input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] sel, output int lat);
        @(negedge clk);
        op_v[k][2*ch +: 2]    = op;
        addr_v[k][8*ch +: 8]  = addr;
        data_v[k][32*ch +: 32] = data;
        sel_v[k][4*ch +: 4]   = sel;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[k][ch]) begin
                lat = n;
                break;
            end
        end
        op_v[k][2*ch +: 2] = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g, ch;
        int cnt [4];
        bit seen;
        for (int k = 0; k < 3; k++) begin
            op_v[k] = '0; addr_v[k] = '0; data_v[k] = '0; sel_v[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done_v[0]), 32'h0);
        check("rst_rd_data", rd_v[0], 32'h0);
        check("rst_grant_id", 32'(gid_v[0]), 32'h0);
        check("rst_busy", 32'(busy_v[0]), 32'h0);
        check("rst_sram_en", 32'(en_v[0]), 32'h0);
        check("rst_sram_we", 32'(we_v[0]), 32'h0);
        check("rst_sram_addr", 32'(sa_v[0]), 32'h0);
        check("rst_sram_di", di_v[0], 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_txn(0, 1, WR, 8'h10, 32'hDEADBEEF, 4'hF, lat);
        check("wr_latency", 32'(lat), 32'd2);
        run_txn(0, 1, RD, 8'h10, 32'h0, 4'h0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_data_ch1", rd_v[0], 32'hDEADBEEF);

        run_txn(0, 2, WR, 8'h20, 32'hAABBCCDD, 4'hF, lat);
        run_txn(0, 2, WR, 8'h20, 32'h11223344, 4'b0101, lat);
        run_txn(0, 0, RD, 8'h20, 32'h0, 4'h0, lat);
        check("byte_enable", rd_v[0], 32'hAA22CC44);
        run_txn(0, 3, WR, 8'h20, 32'h55555555, 4'h0, lat);
        check("sel0_latency", 32'(lat), 32'd2);
        run_txn(0, 3, RD, 8'h20, 32'h0, 4'h0, lat);
        check("sel0_no_write", rd_v[0], 32'hAA22CC44);

        @(negedge clk);
        op_v[0][5:4] = 2'b10;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy_v[0] || done_v[0] != '0) seen = 1'b1;
        end
        op_v[0] = '0;
        check("reserved_op_ignored", 32'(seen), 32'h0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        op_v[0]   = {WR, RD, WR, RD} ^ {2'b10, 2'b00, 2'b10, 2'b00} ^ {2'b10, 2'b00, 2'b10, 2'b00};
        op_v[0]   = {RD, WR, RD, WR};
        addr_v[0] = {8'h20, 8'h42, 8'h10, 8'h40};
        data_v[0] = {32'h0, 32'h22222222, 32'h0, 32'h10101010};
        sel_v[0]  = 16'hFFFF;
        g = 0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int n = 0; n < 200 && g < 12; n++) begin
            @(negedge clk);
            if (done_v[0] != '0) begin
                ch = 0;
                for (int c = 0; c < 4; c++) if (done_v[0][c]) ch = c;
                check("rr_order", 32'(ch), 32'(g % 4));
                cnt[ch]++;
                g++;
            end
        end
        op_v[0] = '0;
        check("rr_grant_count", 32'(g), 32'd12);
        for (int c = 0; c < 4; c++) check("rr_share", 32'(cnt[c]), 32'd3);

        @(negedge clk);
        op_v[0][1:0] = RD;
        addr_v[0][7:0] = 8'h10;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy_v[0]), 32'h0);
        check("abort_done", 32'(done_v[0]), 32'h0);
        check("abort_sram_en", 32'(en_v[0]), 32'h0);
        check("abort_rd_data", rd_v[0], 32'h0);
        check("abort_grant_id", 32'(gid_v[0]), 32'h0);
        op_v[0] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0] != '0) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'h0);

        @(negedge clk);
        op_v[1]   = {WR, 2'b00, 2'b00, WR};
        addr_v[1] = {8'h03, 8'h00, 8'h00, 8'h01};
        data_v[1] = {32'h33333333, 64'h0, 32'h11111111};
        sel_v[1]  = 16'hFFFF;
        g = 0;
        for (int n = 0; n < 100 && g < 6; n++) begin
            @(negedge clk);
            if (done_v[1] != '0) begin
                check("fp_ch0_wins", 32'(done_v[1]), 32'h1);
                g++;
            end
        end
        check("fp_ch0_grants", 32'(g), 32'd6);
        op_v[1][1:0] = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_v[1] != '0) begin
                check("fp_ch3_done", 32'(done_v[1]), 32'h8);
                check("fp_ch3_grant_id", 32'(gid_v[1]), 32'd3);
                seen = 1'b1;
                break;
            end
        end
        check("fp_ch3_served", 32'(seen), 32'h1);
        op_v[1] = '0;

        run_txn(2, 1, WR, 8'h33, 32'hCAFEF00D, 4'hF, lat);
        check("lat3_wr_latency", 32'(lat), 32'd2);
        run_txn(2, 1, RD, 8'h33, 32'h0, 4'h0, lat);
        check("lat3_rd_latency", 32'(lat), 32'd5);
        check("lat3_rd_data", rd_v[2], 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
